// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and memory-load writeback sources onto the single regfile write port.
// Optional macro WB_BYPASS_EN adds a write-to-read bypass on two read ports.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic              alu_v_q, alu_v_d, mem_v_q, mem_v_d;
  logic [ADDR_W-1:0] alu_r_q, alu_r_d, mem_r_q, mem_r_d;
  logic [DATA_W-1:0] alu_dat_q, alu_dat_d, mem_dat_q, mem_dat_d;
  logic              mem_older_q, mem_older_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              grant_alu, grant_mem, alu_load, mem_load, stall_evt;

  always_comb begin
    grant_alu = alu_v_q & (~mem_v_q | ~mem_older_q);
    grant_mem = mem_v_q & (~alu_v_q | mem_older_q);
    alu_ready = reset_n & (~alu_v_q | grant_alu);
    mem_ready = reset_n & (~mem_v_q | grant_mem);
    // Writes to the zero register complete the handshake but are never buffered.
    alu_load  = alu_valid & alu_ready & (alu_reg != ZERO_REG);
    mem_load  = mem_valid & mem_ready & (mem_reg != ZERO_REG);
    stall_evt = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

    alu_v_d   = alu_load | (alu_v_q & ~grant_alu);
    alu_r_d   = alu_load ? alu_reg  : alu_r_q;
    alu_dat_d = alu_load ? alu_data : alu_dat_q;
    mem_v_d   = mem_load | (mem_v_q & ~grant_mem);
    mem_r_d   = mem_load ? mem_reg  : mem_r_q;
    mem_dat_d = mem_load ? mem_data : mem_dat_q;

    // An ALU load is always younger than any surviving or co-loaded MEM entry;
    // a lone MEM load is younger than a surviving ALU entry.
    mem_older_d = mem_older_q;
    if (alu_load)
      mem_older_d = 1'b1;
    else if (mem_load)
      mem_older_d = 1'b0;

    rw_d = grant_alu | grant_mem;
    wr_d = wr_q;
    wd_d = wd_q;
    if (grant_mem) begin
      wr_d = mem_r_q;
      wd_d = mem_dat_q;
    end else if (grant_alu) begin
      wr_d = alu_r_q;
      wd_d = alu_dat_q;
    end

    stall_d = (stall_evt && stall_q != CNT_MAX) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_v_q     <= 1'b0;
      alu_r_q     <= '0;
      alu_dat_q   <= '0;
      mem_v_q     <= 1'b0;
      mem_r_q     <= '0;
      mem_dat_q   <= '0;
      mem_older_q <= 1'b0;
      rw_q        <= 1'b0;
      wr_q        <= '0;
      wd_q        <= '0;
      stall_q     <= '0;
    end else begin
      alu_v_q     <= alu_v_d;
      alu_r_q     <= alu_r_d;
      alu_dat_q   <= alu_dat_d;
      mem_v_q     <= mem_v_d;
      mem_r_q     <= mem_r_d;
      mem_dat_q   <= mem_dat_d;
      mem_older_q <= mem_older_d;
      rw_q        <= rw_d;
      wr_q        <= wr_d;
      wd_q        <= wd_d;
      stall_q     <= stall_d;
    end
  end

  assign RegWrite      = rw_q;
  assign WriteRegister = wr_q;
  assign WriteData     = wd_q;
  assign busy          = alu_v_q | mem_v_q;
  assign stall_count   = stall_q;

`ifdef WB_BYPASS_EN
  assign rd_data1 = (rw_q && wr_q == rd_reg1 && rd_reg1 != ZERO_REG) ? wd_q : rf_data1;
  assign rd_data2 = (rw_q && wr_q == rd_reg2 && rd_reg2 != ZERO_REG) ? wd_q : rf_data2;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite / WriteRegister / WriteData) between two writeback sources: ALU result path and memory-load path.
- Each source gets a one-entry holding buffer with a valid/ready handshake. The arbiter drains the buffers oldest-first, one write per cycle, and drops writes to X31 (hard-wired zero).
- Sits between the pipeline writeback stage and the regfile instance.

Parameters:
- DATA_W, 64, writeback data width; matches regfile WriteData.
- ADDR_W, 5, register index width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU source presents a write.
- alu_ready  out  1  ALU buffer can accept this cycle.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU write data.
- mem_valid  in  1  memory source presents a write.
- mem_ready  out  1  memory buffer can accept this cycle.
- mem_reg  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  memory write data.
- RegWrite  out  1  regfile write enable, registered.
- WriteRegister  out  ADDR_W  regfile write index, registered.
- WriteData  out  DATA_W  regfile write data, registered.
- busy  out  1  either holding buffer occupied.
- stall_count  out  CNT_W  cycles in which some source had valid=1 and ready=0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n). All state changes only on the rising edge of clk.
- Reset (reset_n=0 at an edge):
  - both buffers empty; RegWrite=0; WriteRegister=0; WriteData=0; stall_count=0; age state cleared.
  - Reset mid-operation discards buffered writes without emitting them. alu_ready/mem_ready read 0 while reset_n=0.
- Accept:
  - A source transfers at an edge when valid & ready.
  - ready = buffer empty OR buffer granted this cycle (same-cycle drain and refill allowed).
  - A transfer with reg==31 is accepted (consumes the handshake) but not buffered; it never produces RegWrite.
- Age tracking:
  - Each buffer records its load order.
  - If both buffers load at the same edge, MEM is older (earlier instruction).
  - If a buffer refills while the other stays occupied, the refilled entry is younger.
- Grant, combinational each cycle:
  - Only one buffer valid: grant it.
  - Both valid: grant the older one.
  - Neither valid: no grant.
- Output register:
  - At each edge, RegWrite <= grant_any.
  - When granted, WriteRegister/WriteData <= the granted buffer contents and that buffer empties, unless it is refilled at the same edge.
  - When not granted, WriteRegister/WriteData hold their previous values.
- Latency: a transfer at edge k appears on the outputs after edge k+1 if uncontested; a contested younger entry waits one extra cycle per older write.
- Throughput: one write per cycle sustained. No entry waits more than one cycle behind the other buffer (no starvation).
- Same destination in both buffers: the older write is emitted first, so the younger value is the final regfile content.
- busy = alu_buf_valid | mem_buf_valid.
- stall_count: increments by 1 at each edge where (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready). Saturates at all-ones, no wrap.

Optional Feature:
- WB_BYPASS_EN
- Defined:
  - Adds ports rd_reg1/rd_reg2 (in, ADDR_W), rf_data1/rf_data2 (in, DATA_W, regfile ReadData1/2), and rd_data1/rd_data2 (out, DATA_W).
  - rd_dataN = WriteData when RegWrite=1 and WriteRegister==rd_regN and rd_regN!=31; otherwise rf_dataN.
  - Combinational; covers the write-then-read-same-cycle hazard.
- Undefined: those ports do not exist; no bypass logic.

Test Plan:
- Reset: hold reset_n=0 two cycles with both buffers previously loaded -> RegWrite=0, busy=0, stall_count=0; no stale writes after release.
- Single ALU write: alu_reg=3, alu_data=0x1234 at edge k -> after edge k+1 RegWrite=1, WriteRegister=3, WriteData=0x1234; after k+2 RegWrite=0.
- Simultaneous load: alu_reg=5 (0xA), mem_reg=5 (0xB) at same edge -> MEM write (0xB) emitted first, then ALU (0xA) next cycle; mem_ready=1 throughout, stall_count unchanged.
- X31 drop: mem_reg=31, mem_data=0xFFFF with mem_valid=1 -> handshake completes, RegWrite stays 0 for all following cycles.
- Back-pressure: both sources valid every cycle for 10 cycles with distinct regs -> RegWrite=1 each cycle from the second cycle on, grants alternating strictly oldest-first, stall_count increments once per cycle with a blocked source; force stall_count near all-ones -> holds at all-ones.
- WB_BYPASS_EN: RegWrite=1, WriteRegister=7, WriteData=0x55, rd_reg1=7, rf_data1=0x00 -> rd_data1=0x55; rd_reg1=31 -> rd_data1=rf_data1.
